// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_matrix_pkg
// Shared geometry, frame type and scan state encoding for the LED matrix
// row-scan driver.
// Revision: 1.0
// ---------------------------------------------------------------------------
package led_matrix_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  // One full colour plane, indexed [row][col].
  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage : led_matrix_pkg
`default_nettype wire

// File: rtl/led_matrix_scan_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_timer
// Owns the scan state, the current row and the dwell counter, and emits
// strobes telling the output stage when to capture, light or blank a row.
// Revision: 1.0
// ---------------------------------------------------------------------------
module scan_timer
  import led_matrix_pkg::*;
#(
  parameter int BLANK_CYCLES = 50,
  parameter int SHOW_CYCLES  = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [3:0] row,
  output logic       load_row,
  output logic       blank_row,
  output logic       capture
);

  localparam int MAX_CYCLES = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [3:0]       LAST_ROW   = 4'(ROWS - 1);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       row_nxt;

  // State, dwell counter and row registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      row   <= row_nxt;
    end
  end

  // Next-state logic and output-stage strobes; dropping enable abandons the
  // frame so a later re-enable always restarts from row 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    load_row  = 1'b0;
    blank_row = 1'b0;
    capture   = 1'b0;
    case (state)
      OFF: begin
        if (enable) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          row_nxt   = '0;
          capture   = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_nxt = OFF;
          cnt_nxt   = '0;
          row_nxt   = '0;
          blank_row = 1'b1;
        end else if (cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          load_row  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_nxt = OFF;
          cnt_nxt   = '0;
          row_nxt   = '0;
          blank_row = 1'b1;
        end else if (cnt == SHOW_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          blank_row = 1'b1;
          if (row == LAST_ROW) begin
            row_nxt = '0;
            capture = 1'b1;
          end else begin
            row_nxt = row + 4'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = OFF;
        cnt_nxt   = '0;
        row_nxt   = '0;
        blank_row = 1'b1;
      end
    endcase
  end

endmodule : scan_timer
`default_nettype wire

// File: rtl/led_matrix_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_matrix_scan
// Bicolour 16x16 LED matrix row-scan driver. Frames are shadowed at each
// frame boundary to avoid tearing; every row is preceded by a blank interval.
// Revision: 1.0
// ---------------------------------------------------------------------------
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int BLANK_CYCLES = 50,
  parameter int SHOW_CYCLES  = 2500
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  frame_t          RedPixels,
  input  frame_t          GrnPixels,
  output logic [ROWS-1:0] RowSink,
  output logic [COLS-1:0] RedDriver,
  output logic [COLS-1:0] GrnDriver,
  output logic            frame_start
);

  logic [3:0] row;
  logic       load_row;
  logic       blank_row;
  logic       capture;
  frame_t     red_q;
  frame_t     grn_q;

  scan_timer #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .SHOW_CYCLES  (SHOW_CYCLES)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .row       (row),
    .load_row  (load_row),
    .blank_row (blank_row),
    .capture   (capture)
  );

  // Shadow frames and registered matrix outputs; a row is lit only by
  // load_row, so drivers never change while RowSink is dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_q       <= '0;
      grn_q       <= '0;
      RowSink     <= '0;
      RedDriver   <= '0;
      GrnDriver   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= capture;
      if (capture) begin
        red_q <= RedPixels;
        grn_q <= GrnPixels;
      end
      if (load_row) begin
        RowSink   <= ROWS'(1) << row;
        RedDriver <= red_q[row];
        GrnDriver <= grn_q[row];
      end else if (blank_row) begin
        RowSink   <= '0;
        RedDriver <= '0;
        GrnDriver <= '0;
      end
    end
  end

endmodule : led_matrix_scan
`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_led_matrix_scan
// Directed bench for led_matrix_scan with BLANK_CYCLES=2, SHOW_CYCLES=4
// (row period 6, frame period 96). t counts clock edges since the latest
// capture edge, so row r is lit at t = 6r+2 .. 6r+5.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_led_matrix_scan;
  import led_matrix_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  frame_t      RedPixels = '0;
  frame_t      GrnPixels = '0;
  logic [15:0] RowSink;
  logic [15:0] RedDriver;
  logic [15:0] GrnDriver;
  logic        frame_start;

  int tests = 0;
  int fails = 0;
  int t = 0;
  int last_fs = -1;

  led_matrix_scan #(
    .BLANK_CYCLES (2),
    .SHOW_CYCLES  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .RedPixels   (RedPixels),
    .GrnPixels   (GrnPixels),
    .RowSink     (RowSink),
    .RedDriver   (RedDriver),
    .GrnDriver   (GrnDriver),
    .frame_start (frame_start)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chk_all_dark(input string tag);
    chk({tag, "_row"}, RowSink, 16'h0000);
    chk({tag, "_red"}, RedDriver, 16'h0000);
    chk({tag, "_grn"}, GrnDriver, 16'h0000);
    chk({tag, "_fs"}, {15'd0, frame_start}, 16'h0000);
  endtask

  // One clock, then sample 1 time unit after the edge with invariant checks.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    chk("onehot0", {15'd0, $onehot0(RowSink)}, 16'h0001);
    if (RowSink == 16'h0000) chk("dark_cols", RedDriver | GrnDriver, 16'h0000);
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", 16'(t - last_fs), 16'd96);
      last_fs = t;
    end
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  // Enable was just raised: take the capture edge and rebase t onto it.
  task automatic capture_edge();
    step();
    chk("cap_fs", {15'd0, frame_start}, 16'h0001);
    chk("cap_row", RowSink, 16'h0000);
    t = 0;
    last_fs = 0;
  endtask

  initial begin
    RedPixels[0]    = 16'hA5A5;
    RedPixels[15]   = 16'h8001;
    RedPixels[5][3] = 1'b1;
    GrnPixels[5][3] = 1'b1;

    // Reset state, checked before the first clock edge.
    #1 rst = 1'b1;
    #1 chk_all_dark("reset");
    step();
    step();
    rst = 1'b0;
    step();
    chk_all_dark("idle");

    // Start-up: capture, two blank cycles, then row 0 for four cycles.
    enable = 1'b1;
    capture_edge();
    step();
    chk("st_fs_low", {15'd0, frame_start}, 16'h0000);
    chk("st_blank", RowSink, 16'h0000);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("st_row0", RowSink, 16'h0001);
      chk("st_red0", RedDriver, 16'hA5A5);
      chk("st_grn0", GrnDriver, 16'h0000);
    end
    step();
    chk("st_blank1", RowSink, 16'h0000);

    // Tearing: change green row 7 during row-3 SHOW.
    run_to(21);
    chk("row3", RowSink, 16'h0008);
    GrnPixels[7] = 16'hFFFF;

    // Bicolour pixel in row 5.
    run_to(32);
    chk("bi_row", RowSink, 16'h0020);
    chk("bi_red", RedDriver, 16'h0008);
    chk("bi_grn", GrnDriver, 16'h0008);

    run_to(44);
    chk("tear_row", RowSink, 16'h0080);
    chk("tear_old", GrnDriver, 16'h0000);

    // Row wrap at frame boundary.
    run_to(95);
    chk("r15_row", RowSink, 16'h8000);
    chk("r15_red", RedDriver, 16'h8001);
    run_to(96);
    chk("wrap_fs", {15'd0, frame_start}, 16'h0001);
    chk("wrap_b0", RowSink, 16'h0000);
    run_to(97);
    chk("wrap_fs0", {15'd0, frame_start}, 16'h0000);
    chk("wrap_b1", RowSink, 16'h0000);
    run_to(98);
    chk("wrap_row0", RowSink, 16'h0001);
    chk("wrap_red0", RedDriver, 16'hA5A5);

    run_to(140);
    chk("tear_row2", RowSink, 16'h0080);
    chk("tear_new", GrnDriver, 16'hFFFF);

    run_to(192);
    chk("f2_fs", {15'd0, frame_start}, 16'h0001);
    run_to(288);
    chk("f3_fs", {15'd0, frame_start}, 16'h0001);

    // Enable drop mid row-9 SHOW.
    run_to(345);
    chk("r9_row", RowSink, 16'h0200);
    enable = 1'b0;
    last_fs = -1;
    step();
    chk_all_dark("drop");
    step();
    chk_all_dark("drop2");
    enable = 1'b1;
    capture_edge();
    step();
    chk("re_blank", RowSink, 16'h0000);
    step();
    chk("re_row0", RowSink, 16'h0001);
    chk("re_red0", RedDriver, 16'hA5A5);

    // Asynchronous reset between edges during SHOW.
    run_to(3);
    chk("pre_rst", RowSink, 16'h0001);
    #3 rst = 1'b1;
    last_fs = -1;
    #1 chk_all_dark("async");
    step();
    chk_all_dark("rst_hold");
    step();
    enable = 1'b0;
    rst = 1'b0;
    step();
    chk_all_dark("post_rst");
    step();
    chk_all_dark("post_rst2");
    enable = 1'b1;
    capture_edge();
    step();
    step();
    chk("rs_row0", RowSink, 16'h0001);
    chk("rs_red0", RedDriver, 16'hA5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_led_matrix_scan
`default_nettype wire
